// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the two-master memory arbiter.
//   state_e     : arbiter FSM states (IDLE, BUSY0, BUSY1)
//   GRANT_*     : one-hot grant encodings presented on the grant output
//   bus_req_t   : one master's request fields (addr, wdata, wstrb)
//   TIMEOUT_RDATA : read data returned to a master on a watchdog completion
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  localparam logic [1:0]  GRANT_NONE    = 2'b00;
  localparam logic [1:0]  GRANT_M0      = 2'b01;
  localparam logic [1:0]  GRANT_M1      = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // Master index (0/1) to its one-hot grant code.
  function automatic logic [1:0] grant_of(input logic who);
    return who ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational 2-way selector.
//   req[1:0] : request vector, bit i = master i
//   last     : master that completed most recently
//   any      : at least one request present
//   win      : selected master index (meaningful only when any = 1)
// On a tie, ROUND_ROBIN = 1 picks the master that did not go last;
// ROUND_ROBIN = 0 always picks master 0.
module rr_pick #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       win
);

  always_comb begin
    any = |req;
    if (&req) win = ROUND_ROBIN ? ~last : 1'b0;
    else      win = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready slave bus between two masters
// (m0 = CPU core, m1 = loader/DMA). One transaction at a time; the grant is
// held until the slave answers, the master aborts, or the watchdog fires.
//   clk, rst              : clock, synchronous active-high reset
//   mX_valid/addr/wdata/wstrb : master X request (wstrb = 0 means read)
//   mX_ready/rdata        : master X completion pulse and read data
//   s_valid/addr/wdata/wstrb  : request forwarded to the slave
//   s_ready/rdata         : slave completion pulse and read data
//   grant                 : one-hot registered owner (00 = idle)
//   timeout_err           : one-cycle pulse after a watchdog completion
// Parameters: ROUND_ROBIN (tie policy), TIMEOUT (watchdog cycles, 0 = off),
// CNT_W (counter width, 2^CNT_W must exceed TIMEOUT).
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state;
  logic             last;
  logic [CNT_W-1:0] cnt;

  bus_req_t [1:0] mreq;
  logic     [1:0] mvalid;
  logic           pick_any, pick_win;
  logic           busy, owner, own_valid;
  logic           done, wd_fire, complete;

  assign mreq[0] = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign mreq[1] = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign mvalid  = {m1_valid, m0_valid};

  rr_pick #(.ROUND_ROBIN(ROUND_ROBIN != 0)) u_pick (
    .req  (mvalid),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  // Owner index follows the state register; in IDLE it defaults to m0,
  // which only matters for the (ignored) slave field mux.
  assign busy      = (state == BUSY0) || (state == BUSY1);
  assign owner     = (state == BUSY1);
  assign own_valid = mvalid[owner];

  // A master that dropped valid has aborted: any s_ready that cycle is
  // discarded. Reset also suppresses completions so no master sees a pulse
  // for a transaction being torn down. s_ready beats the watchdog.
  assign done     = busy && own_valid && s_ready && !rst;
  assign wd_fire  = WD_EN && busy && own_valid && !s_ready && !rst && (cnt == TO_LAST);
  assign complete = done || wd_fire;

  assign s_valid = busy && own_valid && !rst;
  assign {s_addr, s_wdata, s_wstrb} = mreq[owner];

  assign m0_ready = complete && !owner;
  assign m1_ready = complete &&  owner;
  // Both masters see the slave data; only a watchdog completion zeroes it.
  assign m0_rdata = (wd_fire && !owner) ? TIMEOUT_RDATA : s_rdata;
  assign m1_rdata = (wd_fire &&  owner) ? TIMEOUT_RDATA : s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= GRANT_NONE;
      last        <= 1'b1;       // m0 wins the first tie
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_any) begin
            state <= pick_win ? BUSY1 : BUSY0;
            grant <= grant_of(pick_win);
          end
        end
        BUSY0, BUSY1: begin
          if (!own_valid) begin
            // abort: back to IDLE, no completion, fairness state untouched
            state <= IDLE;
            grant <= GRANT_NONE;
            cnt   <= '0;
          end else if (complete) begin
            state <= IDLE;
            grant <= GRANT_NONE;
            last  <= owner;
            cnt   <= '0;
          end else if (WD_EN && cnt != '1) begin
            cnt <= cnt + 1'b1;       // saturating
          end
        end
        default: begin
          state <= IDLE;
          grant <= GRANT_NONE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Instance A: round-robin, TIMEOUT = 4.
// Instance B: fixed priority, watchdog disabled; used for the starvation case.
// Inputs change on the falling edge, outputs are checked 1 ns later.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready_a, s_ready_b;

  logic        m0_ready_a, m1_ready_a, s_valid_a, timeout_err_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a;
  logic [3:0]  s_wstrb_a;
  logic [1:0]  grant_a;

  logic        m0_ready_b, m1_ready_b, s_valid_b, timeout_err_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, s_addr_b, s_wdata_b;
  logic [3:0]  s_wstrb_b;
  logic [1:0]  grant_b;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready_a), .m0_rdata(m0_rdata_a),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready_a), .m1_rdata(m1_rdata_a),
    .s_valid(s_valid_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wstrb(s_wstrb_a),
    .s_ready(s_ready_a), .s_rdata(s_rdata),
    .grant(grant_a), .timeout_err(timeout_err_a)
  );

  mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready_b), .m0_rdata(m0_rdata_b),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready_b), .m1_rdata(m1_rdata_b),
    .s_valid(s_valid_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wstrb(s_wstrb_b),
    .s_ready(s_ready_b), .s_rdata(s_rdata),
    .grant(grant_b), .timeout_err(timeout_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic test_reset();
    rst = 1; m0_valid = 1; m1_valid = 1; s_ready_a = 1; s_ready_b = 1;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b00) begin n_err++; $display("FAIL rst_grant got %b want 00", grant_a); end
    n_cmp++; if (s_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_s_valid got %b want 0", s_valid_a); end
    n_cmp++; if ({m1_ready_a, m0_ready_a} !== 2'b00) begin n_err++; $display("FAIL rst_ready got %b want 00", {m1_ready_a, m0_ready_a}); end
    n_cmp++; if (timeout_err_a !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err got %b want 0", timeout_err_a); end
    @(negedge clk);
    rst = 0; m0_valid = 0; m1_valid = 0; s_ready_a = 0; s_ready_b = 0; #1;
    n_cmp++; if (grant_a !== 2'b00) begin n_err++; $display("FAIL rst_rel_grant got %b want 00", grant_a); end
  endtask

  task automatic test_m0_read();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0; #1;
    n_cmp++; if (s_valid_a !== 1'b0) begin n_err++; $display("FAIL rd_latency s_valid got %b want 0", s_valid_a); end
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b01) begin n_err++; $display("FAIL rd_grant got %b want 01", grant_a); end
    n_cmp++; if (s_valid_a !== 1'b1 || s_addr_a !== 32'h100) begin n_err++; $display("FAIL rd_s_req got v=%b a=%h want v=1 a=00000100", s_valid_a, s_addr_a); end
    n_cmp++; if (m0_ready_a !== 1'b0) begin n_err++; $display("FAIL rd_early_ready got %b want 0", m0_ready_a); end
    @(negedge clk); #1;
    n_cmp++; if (m0_ready_a !== 1'b0) begin n_err++; $display("FAIL rd_wait_ready got %b want 0", m0_ready_a); end
    @(negedge clk);
    s_ready_a = 1; s_rdata = 32'hCAFEF00D; #1;
    n_cmp++; if (m0_ready_a !== 1'b1 || m0_rdata_a !== 32'hCAFEF00D) begin n_err++; $display("FAIL rd_done got rdy=%b d=%h want rdy=1 d=cafef00d", m0_ready_a, m0_rdata_a); end
    n_cmp++; if (m1_ready_a !== 1'b0) begin n_err++; $display("FAIL rd_m1_ready got %b want 0", m1_ready_a); end
    @(negedge clk);
    s_ready_a = 0; m0_valid = 0; #1;
    n_cmp++; if (grant_a !== 2'b00 || m0_ready_a !== 1'b0) begin n_err++; $display("FAIL rd_idle got g=%b rdy=%b want g=00 rdy=0", grant_a, m0_ready_a); end
  endtask

  task automatic test_m1_write();
    @(negedge clk);
    m0_addr = 32'hDEAD0000; m0_wdata = 32'hBEEF; m0_wstrb = 4'hF;
    m1_valid = 1; m1_addr = 32'h0100_0004; m1_wdata = 32'h42; m1_wstrb = 4'b0001;
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b10) begin n_err++; $display("FAIL wr_grant got %b want 10", grant_a); end
    n_cmp++; if (s_addr_a !== 32'h0100_0004 || s_wdata_a !== 32'h42 || s_wstrb_a !== 4'b0001)
      begin n_err++; $display("FAIL wr_fields got a=%h d=%h s=%b want a=01000004 d=00000042 s=0001", s_addr_a, s_wdata_a, s_wstrb_a); end
    s_ready_a = 1; #1;
    n_cmp++; if ({m1_ready_a, m0_ready_a} !== 2'b10) begin n_err++; $display("FAIL wr_ready got %b want 10", {m1_ready_a, m0_ready_a}); end
    @(negedge clk);
    s_ready_a = 0; m1_valid = 0; #1;
    n_cmp++; if (grant_a !== 2'b00) begin n_err++; $display("FAIL wr_idle got %b want 00", grant_a); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [0:7];
    logic [1:0] exp_b [0:7];
    exp_a = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_b = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    @(negedge clk);
    rst = 1; m0_valid = 0; m1_valid = 0; s_ready_a = 0; s_ready_b = 0;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0; s_rdata = 32'h0;
    @(negedge clk);
    rst = 0; m0_valid = 1; m1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      s_ready_a = s_valid_a; s_ready_b = s_valid_b; #1;
      n_cmp++; if (grant_a !== exp_a[i]) begin n_err++; $display("FAIL rr_seq[%0d] got %b want %b", i, grant_a, exp_a[i]); end
      n_cmp++; if (grant_b !== exp_b[i]) begin n_err++; $display("FAIL fixed_seq[%0d] got %b want %b", i, grant_b, exp_b[i]); end
      n_cmp++; if (m1_ready_b !== 1'b0) begin n_err++; $display("FAIL fixed_m1_ready[%0d] got %b want 0", i, m1_ready_b); end
    end
    @(negedge clk);
    m0_valid = 0; m1_valid = 0; s_ready_a = 0; s_ready_b = 0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h200; m0_wstrb = 4'h0; s_rdata = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (grant_a !== 2'b01 || m0_ready_a !== 1'b0 || timeout_err_a !== 1'b0)
        begin n_err++; $display("FAIL to_wait[%0d] got g=%b rdy=%b err=%b want g=01 rdy=0 err=0", c, grant_a, m0_ready_a, timeout_err_a); end
    end
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h300; m1_wstrb = 4'h0; #1;
    n_cmp++; if (m0_ready_a !== 1'b1 || m0_rdata_a !== 32'h0) begin n_err++; $display("FAIL to_fire got rdy=%b d=%h want rdy=1 d=00000000", m0_ready_a, m0_rdata_a); end
    n_cmp++; if (m1_rdata_a !== 32'h1234_5678 || timeout_err_a !== 1'b0) begin n_err++; $display("FAIL to_fire_side got m1d=%h err=%b want m1d=12345678 err=0", m1_rdata_a, timeout_err_a); end
    @(negedge clk);
    m0_valid = 0; #1;
    n_cmp++; if (timeout_err_a !== 1'b1 || grant_a !== 2'b00) begin n_err++; $display("FAIL to_err got err=%b g=%b want err=1 g=00", timeout_err_a, grant_a); end
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b10 || timeout_err_a !== 1'b0) begin n_err++; $display("FAIL to_next got g=%b err=%b want g=10 err=0", grant_a, timeout_err_a); end
    s_ready_a = 1; s_rdata = 32'h5555_AAAA; #1;
    n_cmp++; if (m1_ready_a !== 1'b1 || m1_rdata_a !== 32'h5555_AAAA) begin n_err++; $display("FAIL to_next_done got rdy=%b d=%h want rdy=1 d=5555aaaa", m1_ready_a, m1_rdata_a); end
    @(negedge clk);
    m1_valid = 0; s_ready_a = 0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h400;
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b01) begin n_err++; $display("FAIL ab_grant got %b want 01", grant_a); end
    @(negedge clk);
    m0_valid = 0; s_ready_a = 1; s_rdata = 32'h7777_0000; #1;
    n_cmp++; if ({m1_ready_a, m0_ready_a} !== 2'b00) begin n_err++; $display("FAIL ab_ready got %b want 00", {m1_ready_a, m0_ready_a}); end
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b00 || s_valid_a !== 1'b0) begin n_err++; $display("FAIL ab_idle got g=%b v=%b want g=00 v=0", grant_a, s_valid_a); end
    n_cmp++; if ({m1_ready_a, m0_ready_a} !== 2'b00) begin n_err++; $display("FAIL idle_s_ready got %b want 00", {m1_ready_a, m0_ready_a}); end
    @(negedge clk);
    s_ready_a = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h500;
    @(negedge clk);
    s_ready_a = 1; s_rdata = 32'h1; #1;
    n_cmp++; if (m0_ready_a !== 1'b1) begin n_err++; $display("FAIL rm_pre_done got %b want 1", m0_ready_a); end
    @(negedge clk);
    s_ready_a = 0; m0_valid = 0; m1_valid = 1; m1_addr = 32'h600;
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b10) begin n_err++; $display("FAIL rm_busy1 got %b want 10", grant_a); end
    rst = 1; s_ready_a = 1; #1;
    n_cmp++; if (m1_ready_a !== 1'b0 || s_valid_a !== 1'b0) begin n_err++; $display("FAIL rm_in_rst got rdy=%b v=%b want rdy=0 v=0", m1_ready_a, s_valid_a); end
    @(negedge clk);
    rst = 0; s_ready_a = 0; m0_valid = 1; #1;
    n_cmp++; if (grant_a !== 2'b00 || s_valid_a !== 1'b0) begin n_err++; $display("FAIL rm_after got g=%b v=%b want g=00 v=0", grant_a, s_valid_a); end
    @(negedge clk); #1;
    n_cmp++; if (grant_a !== 2'b01) begin n_err++; $display("FAIL rm_first_tie got %b want 01", grant_a); end
    @(negedge clk);
    m0_valid = 0; m1_valid = 0;
  endtask

  initial begin
    rst = 1; m0_valid = 0; m1_valid = 0; s_ready_a = 0; s_ready_b = 0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; s_rdata = '0;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_round_robin();
    test_timeout();
    test_abort();
    test_reset_mid();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
